cp0_irq_ctrl: RTL

CP0_IRQ_CTRL -- requirements
Module: cp0_irq_ctrl

---
 rtl/cp0_irq_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: SR/Cause/EPC/PRId registers, a one-cycle hwint
// sampler, an armed flag and a RUN/HANDLER state machine that drives the
// take-interrupt request to the next-PC unit.
module cp0_irq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hwint,
  input  logic        PCWr,
  input  logic [29:0] pc_next,
  input  logic        eret,
  input  logic        mtc0,
  input  logic [4:0]  sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [29:0] epc,
  output logic        exl
);

  localparam int unsigned HW_W   = 6;
  localparam int unsigned PC_W   = 30;
  localparam int unsigned DATA_W = 32;

  localparam logic [4:0]        SEL_SR    = 5'd12;
  localparam logic [4:0]        SEL_CAUSE = 5'd13;
  localparam logic [4:0]        SEL_EPC   = 5'd14;
  localparam logic [4:0]        SEL_PRID  = 5'd15;
  localparam logic [DATA_W-1:0] PRID_VAL  = 32'h0000_0100;

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [HW_W-1:0] im;
  logic            ie;
  logic [HW_W-1:0] ip;
  logic [PC_W-1:0] epc_q;
  logic            armed;

  logic wr_sr;
  logic wr_epc;
  logic do_eret;

  // Strobe decode: every CP0 side effect is qualified by the PC update.
  always_comb begin
    wr_sr   = mtc0 && PCWr && (sel == SEL_SR);
    wr_epc  = mtc0 && PCWr && (sel == SEL_EPC);
    do_eret = eret && PCWr;
    irq     = armed && PCWr && !eret;
  end

  // EXL state register; the FSM state is SR.EXL itself.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next state: mtc0 write, then eret clears, then a take sets (take wins).
  always_comb begin
    state_next = state;
    if (wr_sr)   state_next = wdata[1] ? HANDLER : RUN;
    if (do_eret) state_next = RUN;
    if (irq)     state_next = HANDLER;
  end

  // SR mask/enable, IP sampler, EPC and the registered armed flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      im    <= '0;
      ie    <= 1'b0;
      ip    <= '0;
      epc_q <= '0;
      armed <= 1'b0;
    end else begin
      ip    <= hwint;
      armed <= (|(ip & im)) && ie && (state == RUN);
      if (wr_sr) begin
        im <= wdata[15:10];
        ie <= wdata[0];
      end
      if (irq)         epc_q <= pc_next;
      else if (wr_epc) epc_q <= wdata[31:2];
    end
  end

  // mfc0 read mux.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_SR:    rdata = {16'b0, im, 8'b0, exl, ie};
      SEL_CAUSE: rdata = {16'b0, ip, 10'b0};
      SEL_EPC:   rdata = {epc_q, 2'b00};
      SEL_PRID:  rdata = PRID_VAL;
      default:   rdata = '0;
    endcase
  end

  assign exl = (state == HANDLER);
  assign epc = epc_q;

endmodule
